mem_access_hs: RTL and testbench

MEM_ACCESS_HS -- requirements
Module: mem_access_hs

---
 rtl/mem_access_hs_pkg.sv | 45 ++++
 rtl/mem_access_hs_lane_align.sv | 77 +++++++
 rtl/mem_access_hs.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access_hs.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_hs_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_hs_pkg
// Shared constants for the memory-access stage: default datapath width, the
// access-size encoding, and helpers for byte enables and alignment.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_access_hs_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      BYTE  = 2'd0,
      HALF  = 2'd1,
      WORD  = 2'd2,
      DWORD = 2'd3
   } data_size_e;

   // Byte-enable pattern for an access of the given size, shifted to the byte
   // offset inside an 8-byte word. 32-bit users keep the low four bits.
   function automatic logic [7:0] byte_en(input data_size_e size, input logic [2:0] offset);
      logic [7:0] base;
      case (size)
         BYTE:    base = 8'h01;
         HALF:    base = 8'h03;
         WORD:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << offset;
   endfunction

   // Natural alignment check. DWORD only exists on a 64-bit datapath, so on
   // a 32-bit datapath it always reports misaligned.
   function automatic logic is_aligned(input data_size_e size, input logic [2:0] addr_lo,
                                       input int xlen);
      logic ok;
      case (size)
         BYTE:    ok = 1'b1;
         HALF:    ok = ~addr_lo[0];
         WORD:    ok = (addr_lo[1:0] == 2'b00);
         default: ok = (xlen == 64) && (addr_lo == 3'b000);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_access_hs_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane steering for the memory stage.
//   size, offset   : access size and byte offset inside the XLEN word
//   is_unsigned    : zero-extend loads instead of sign-extending
//   store_data     : raw store data (rs2), replicated onto the lanes
//   load_raw       : raw word returned by data memory
//   be             : byte enables for the access
//   wdata          : lane-steered store data
//   load_data      : load value shifted down and extended to XLEN
// -----------------------------------------------------------------------------
module mem_lane_align
   import mem_access_hs_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  data_size_e        size,
   input  logic              is_unsigned,
   input  logic [2:0]        offset,
   input  logic [XLEN-1:0]   store_data,
   input  logic [XLEN-1:0]   load_raw,
   output logic [XLEN/8-1:0] be,
   output logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   load_data
);

   logic [7:0]      be_full;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] mask;
   logic            sign;

   assign be_full = byte_en(size, offset);
   assign be      = be_full[XLEN/8-1:0];

   // Replicating the low bytes into every lane means the addressed lanes
   // always carry the right bytes whatever the offset.
   always_comb begin
      wdata = '0;
      for (int i = 0; i < XLEN/8; i++) begin
         case (size)
            BYTE:    wdata[i*8 +: 8] = store_data[7:0];
            HALF:    wdata[i*8 +: 8] = store_data[(i%2)*8 +: 8];
            WORD:    wdata[i*8 +: 8] = store_data[(i%4)*8 +: 8];
            default: wdata[i*8 +: 8] = store_data[i*8 +: 8];
         endcase
      end
   end

   assign shifted = load_raw >> {offset, 3'b000};

   // Extension via a keep-mask avoids zero-width replications when the
   // access is as wide as the datapath.
   always_comb begin
      mask = '0;
      sign = 1'b0;
      case (size)
         BYTE: begin
            mask[7:0] = '1;
            sign      = shifted[7];
         end
         HALF: begin
            mask[15:0] = '1;
            sign       = shifted[15];
         end
         WORD: begin
            mask[31:0] = '1;
            sign       = shifted[31];
         end
         default: begin
            mask = '1;
            sign = 1'b0;
         end
      endcase
      load_data = (shifted & mask) | ((sign & ~is_unsigned) ? ~mask : '0);
   end

endmodule

// File: rtl/mem_access_hs.sv
// -----------------------------------------------------------------------------
// mem_access_hs
// Memory-access pipeline stage with a request/grant data-memory handshake.
//   clk, rst_n               : clock, asynchronous active-low reset
//   valid_i, sel_rd_i, mem_re_i, mem_we_i, mem_size_i, mem_unsigned_i,
//   alu_result_i, data_i     : instruction arriving from execute
//   stall_i                  : downstream hold
//   stall_o                  : freezes upstream while an access is in flight
//   misaligned_o             : registered misaligned-access flag
//   dmem_*                   : data-memory request / response channel
//   mem_re_o, mem_we_o, sel_rd_o, alu_result_o, data_o : registered to WB
//   data_bypass_o            : forwarding value
//
// Handshake: dmem_req_o is held high with addr/be/we/wdata stable from the
// first REQ cycle until the cycle dmem_gnt_i is sampled high; that cycle
// completes the request. For loads the read data is taken in the first cycle
// dmem_rvalid_i is high at or after the grant cycle; rvalid seen while no
// load is outstanding is ignored. Upstream inputs stay frozen while stall_o=1.
//
// FSM state is visible as state_q (IDLE/REQ/WAIT/DONE).
// -----------------------------------------------------------------------------
module mem_access_hs
   import mem_access_hs_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,  // 32 or 64
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic [4:0]            sel_rd_i,
   input  logic                  mem_re_i,
   input  logic                  mem_we_i,
   input  data_size_e            mem_size_i,
   input  logic                  mem_unsigned_i,
   input  logic [XLEN-1:0]       alu_result_i,
   input  logic [XLEN-1:0]       data_i,
   input  logic                  stall_i,
   output logic                  stall_o,
   output logic                  misaligned_o,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [ADDR_WIDTH-1:0] dmem_addr_o,
   output logic [XLEN/8-1:0]     dmem_be_o,
   output logic [XLEN-1:0]       dmem_wdata_o,
   input  logic                  dmem_gnt_i,
   input  logic                  dmem_rvalid_i,
   input  logic [XLEN-1:0]       dmem_rdata_i,
   output logic                  mem_re_o,
   output logic                  mem_we_o,
   output logic [4:0]            sel_rd_o,
   output logic [XLEN-1:0]       alu_result_o,
   output logic [XLEN-1:0]       data_o,
   output logic [XLEN-1:0]       data_bypass_o
);

   localparam int         OFF_W    = $clog2(XLEN/8);
   localparam logic [2:0] OFF_MASK = 3'(XLEN/8 - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]            state_q, state_d;

   // Transaction registers captured when an access is accepted in IDLE.
   logic [ADDR_WIDTH-1:0] addr_q;
   data_size_e            size_q;
   logic                  uns_q;
   logic                  we_q;
   logic                  re_q;
   logic [XLEN/8-1:0]     be_q;
   logic [XLEN-1:0]       wdata_q;
   logic [4:0]            rd_q;
   logic [XLEN-1:0]       alu_q;
   logic [XLEN-1:0]       data_q;
   logic [XLEN-1:0]       rdata_q;

   logic                  in_idle;
   logic                  is_mem;
   logic                  aligned;
   logic                  access;
   logic                  misaligned_now;
   logic                  rdata_take;
   logic                  out_en;

   data_size_e            al_size;
   logic [2:0]            al_off;
   logic [XLEN/8-1:0]     al_be;
   logic [XLEN-1:0]       al_wdata;
   logic [XLEN-1:0]       al_load;

   assign in_idle        = (state_q == S_IDLE);
   assign is_mem         = valid_i & (mem_re_i | mem_we_i);
   assign aligned        = is_aligned(mem_size_i, alu_result_i[2:0], XLEN);
   assign access         = in_idle & is_mem & aligned;
   assign misaligned_now = is_mem & ~aligned;

   // One aligner serves both directions: in IDLE it steers the incoming
   // store, afterwards it extends the captured load word.
   assign al_size = in_idle ? mem_size_i : size_q;
   assign al_off  = in_idle ? (alu_result_i[2:0] & OFF_MASK) : (addr_q[2:0] & OFF_MASK);

   mem_lane_align #(.XLEN(XLEN)) u_align (
      .size        (al_size),
      .is_unsigned (uns_q),
      .offset      (al_off),
      .store_data  (data_i),
      .load_raw    (rdata_q),
      .be          (al_be),
      .wdata       (al_wdata),
      .load_data   (al_load)
   );

   // Read data arriving together with the grant is accepted immediately.
   assign rdata_take = dmem_rvalid_i &
                       ((state_q == S_WAIT) | ((state_q == S_REQ) & dmem_gnt_i & ~we_q));

   always_comb begin
      state_d = state_q;
      stall_o = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (access) begin
               state_d = S_REQ;
               stall_o = 1'b1;
            end
         end
         S_REQ: begin
            stall_o = 1'b1;
            if (dmem_gnt_i) begin
               if (we_q || dmem_rvalid_i) state_d = S_DONE;
               else                       state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            stall_o = 1'b1;
            if (dmem_rvalid_i) state_d = S_DONE;
         end
         S_DONE: begin
            if (!stall_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         size_q  <= BYTE;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         alu_q   <= '0;
         data_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (access) begin
            addr_q  <= alu_result_i[ADDR_WIDTH-1:0];
            size_q  <= mem_size_i;
            uns_q   <= mem_unsigned_i;
            we_q    <= mem_we_i;
            re_q    <= mem_re_i & ~mem_we_i;  // a store wins if both are set
            be_q    <= al_be;
            wdata_q <= al_wdata;
            rd_q    <= sel_rd_i;
            alu_q   <= alu_result_i;
            data_q  <= data_i;
         end
         if (rdata_take) rdata_q <= dmem_rdata_i;
      end
   end

   // Results retire from IDLE (anything that is not an accepted access) or
   // from DONE, and only while downstream is not holding.
   assign out_en = ~stall_i & ((in_idle & ~access) | (state_q == S_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_re_o     <= 1'b0;
         mem_we_o     <= 1'b0;
         misaligned_o <= 1'b0;
         sel_rd_o     <= '0;
         alu_result_o <= '0;
         data_o       <= '0;
      end else if (out_en) begin
         if (state_q == S_DONE) begin
            mem_re_o     <= re_q;
            mem_we_o     <= we_q;
            misaligned_o <= 1'b0;
            sel_rd_o     <= rd_q;
            alu_result_o <= alu_q;
            data_o       <= re_q ? al_load : data_q;
         end else begin
            // A memory instruction reaching this branch is misaligned.
            mem_re_o     <= 1'b0;
            mem_we_o     <= 1'b0;
            misaligned_o <= misaligned_now;
            sel_rd_o     <= sel_rd_i;
            alu_result_o <= alu_result_i;
            data_o       <= data_i;
         end
      end
   end

   assign dmem_req_o    = (state_q == S_REQ);
   assign dmem_we_o     = dmem_req_o & we_q;
   assign dmem_addr_o   = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
   assign dmem_be_o     = be_q;
   assign dmem_wdata_o  = wdata_q;
   assign data_bypass_o = ((state_q == S_DONE) && re_q) ? al_load : alu_result_i;

endmodule

// File: tb/tb_mem_access_hs.sv
// -----------------------------------------------------------------------------
// tb_mem_access_hs
// Directed and random instructions against mem_access_hs (XLEN=32). The bench
// plays the data memory, computes the expected lane/extension/timing results
// from byte arithmetic, and checks them with immediate assertions.
// -----------------------------------------------------------------------------
module tb_mem_access_hs;
   import mem_access_hs_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        valid_i;
   logic [4:0]  sel_rd_i;
   logic        mem_re_i;
   logic        mem_we_i;
   data_size_e  mem_size_i;
   logic        mem_unsigned_i;
   logic [31:0] alu_result_i;
   logic [31:0] data_i;
   logic        stall_i;
   logic        stall_o;
   logic        misaligned_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [11:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_gnt_i;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        mem_re_o;
   logic        mem_we_o;
   logic [4:0]  sel_rd_o;
   logic [31:0] alu_result_o;
   logic [31:0] data_o;
   logic [31:0] data_bypass_o;

   int tests = 0;
   int fails = 0;

   // Last retired results, used to check that outputs hold while stalled.
   logic [31:0] prev_alu;
   logic [31:0] prev_data;

   mem_access_hs #(.XLEN(32), .ADDR_WIDTH(12)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .valid_i        (valid_i),
      .sel_rd_i       (sel_rd_i),
      .mem_re_i       (mem_re_i),
      .mem_we_i       (mem_we_i),
      .mem_size_i     (mem_size_i),
      .mem_unsigned_i (mem_unsigned_i),
      .alu_result_i   (alu_result_i),
      .data_i         (data_i),
      .stall_i        (stall_i),
      .stall_o        (stall_o),
      .misaligned_o   (misaligned_o),
      .dmem_req_o     (dmem_req_o),
      .dmem_we_o      (dmem_we_o),
      .dmem_addr_o    (dmem_addr_o),
      .dmem_be_o      (dmem_be_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_gnt_i     (dmem_gnt_i),
      .dmem_rvalid_i  (dmem_rvalid_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .mem_re_o       (mem_re_o),
      .mem_we_o       (mem_we_o),
      .sel_rd_o       (sel_rd_o),
      .alu_result_o   (alu_result_o),
      .data_o         (data_o),
      .data_bypass_o  (data_bypass_o)
   );

   // Clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one instruction from a point just after a falling edge, acts as
   // the memory (grant after g extra REQ cycles, rvalid r cycles after grant),
   // holds stall_i for d cycles once the result is ready, then checks the
   // retired outputs. Returns just after a falling edge.
   task automatic run_instr(input logic v, input logic re, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] data,
                            input logic [4:0] rd, input int g, input int r,
                            input logic [31:0] rdata, input int d);
      int          nbytes, off, stall_cnt;
      logic        is_mem, ok, acc, mis;
      logic [63:0] lmask, v64;
      logic [31:0] lanes, ld, exp_data, exp_w;
      logic [3:0]  exp_be;

      nbytes = 1 << sz;
      off    = int'(addr[1:0]);
      is_mem = v && (re || we);
      ok     = (sz != 2'd3) && ((int'(addr[2:0]) % nbytes) == 0);
      acc    = is_mem && ok;
      mis    = is_mem && !ok;
      lmask  = (64'd1 << (8*nbytes)) - 64'd1;
      v64    = ({32'd0, rdata} >> (8*off)) & lmask;
      if (!uns && v64[8*nbytes-1]) v64 = v64 | ~lmask;
      ld       = v64[31:0];
      lanes    = 32'(lmask << (8*off));
      exp_w    = (data << (8*off)) & lanes;
      exp_be   = 4'(((1 << nbytes) - 1) << off);
      exp_data = (acc && re) ? ld : data;

      valid_i        = v;
      mem_re_i       = re;
      mem_we_i       = we;
      mem_size_i     = data_size_e'(sz);
      mem_unsigned_i = uns;
      alu_result_i   = addr;
      data_i         = data;
      sel_rd_i       = rd;
      dmem_gnt_i     = 1'b0;
      dmem_rvalid_i  = 1'b0;
      stall_i        = 1'b0;

      if (acc) begin
         stall_cnt = 0;
         #1;
         chk("issue_stall", stall_o, 1);
         chk("issue_req", dmem_req_o, 0);
         if (stall_o) stall_cnt++;
         @(negedge clk);
         for (int k = 0; k <= g; k++) begin
            #1;
            chk("req_active", dmem_req_o, 1);
            chk("req_addr", dmem_addr_o, addr[11:0] & 12'hFFC);
            chk("req_be", dmem_be_o, exp_be);
            chk("req_we", dmem_we_o, we);
            chk("req_wdata", dmem_wdata_o & lanes, (we ? exp_w : (dmem_wdata_o & lanes)));
            chk("req_hold_alu", alu_result_o, prev_alu);
            if (stall_o) stall_cnt++;
            if (k == g) begin
               dmem_gnt_i = 1'b1;
               if (re && r == 0) begin
                  dmem_rvalid_i = 1'b1;
                  dmem_rdata_i  = rdata;
               end
            end
            @(negedge clk);
            dmem_gnt_i    = 1'b0;
            dmem_rvalid_i = 1'b0;
         end
         if (re) begin
            for (int k = 1; k <= r; k++) begin
               #1;
               chk("wait_req", dmem_req_o, 0);
               chk("wait_hold_data", data_o, prev_data);
               if (stall_o) stall_cnt++;
               if (k == r) begin
                  dmem_rvalid_i = 1'b1;
                  dmem_rdata_i  = rdata;
               end
               @(negedge clk);
               dmem_rvalid_i = 1'b0;
            end
         end
         for (int k = 0; k <= d; k++) begin
            stall_i = (k < d);
            #1;
            chk("done_stall", stall_o, 0);
            chk("done_req", dmem_req_o, 0);
            chk("done_bypass", data_bypass_o, re ? ld : addr);
            if (k < d) chk("done_hold_data", data_o, prev_data);
            @(negedge clk);
         end
         stall_i = 1'b0;
         chk("stall_cycles", 64'(stall_cnt), 64'(2 + g + (re ? r : 0)));
      end else begin
         for (int k = 0; k <= d; k++) begin
            stall_i = (k < d);
            #1;
            chk("pass_stall", stall_o, 0);
            chk("pass_req", dmem_req_o, 0);
            chk("pass_bypass", data_bypass_o, addr);
            if (k < d) chk("pass_hold_alu", alu_result_o, prev_alu);
            @(negedge clk);
         end
         stall_i = 1'b0;
      end

      #1;
      chk("out_re", mem_re_o, acc && re);
      chk("out_we", mem_we_o, acc && we);
      chk("out_misaligned", misaligned_o, mis);
      chk("out_rd", sel_rd_o, rd);
      chk("out_alu", alu_result_o, addr);
      chk("out_data", data_o, exp_data);
      prev_alu  = addr;
      prev_data = exp_data;
   endtask

   initial begin
      logic        v, re, we, uns;
      logic [1:0]  sz;
      logic [31:0] addr, data, rdata;
      logic [4:0]  rd;
      int          kind;

      rst_n = 1'b0;
      valid_i = 1'b0; sel_rd_i = '0; mem_re_i = 1'b0; mem_we_i = 1'b0;
      mem_size_i = BYTE; mem_unsigned_i = 1'b0; alu_result_i = '0; data_i = '0;
      stall_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
      prev_alu = '0;
      prev_data = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", stall_o, 0);
      chk("rst_req", dmem_req_o, 0);
      chk("rst_misaligned", misaligned_o, 0);
      chk("rst_re", mem_re_o, 0);
      chk("rst_data", data_o, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // SW word at 0x100, grant on the second REQ cycle: three stall cycles
      run_instr(1, 0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 5'd1, 1, 0, 32'h0, 0);
      // LB at 0x103, signed then unsigned
      run_instr(1, 1, 0, 2'd0, 0, 32'h103, 32'hDEADBEEF, 5'd2, 0, 1, 32'h80123456, 0);
      chk("lb_signed", data_o, 32'hFFFFFF80);
      run_instr(1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 5'd3, 2, 2, 32'h80654321, 0);
      chk("lb_unsigned", data_o, 32'h00000080);
      // LH at 0x101 is misaligned; the next instruction clears the flag
      run_instr(1, 1, 0, 2'd1, 0, 32'h101, 32'h11, 5'd4, 0, 0, 32'h0, 0);
      run_instr(1, 0, 0, 2'd0, 0, 32'h42, 32'h22, 5'd5, 0, 0, 32'h0, 0);
      // LW with grant and rvalid together: no WAIT cycle
      run_instr(1, 1, 0, 2'd2, 0, 32'h104, 32'h0, 5'd6, 0, 0, 32'hA5A55A5A, 0);
      // DWORD on a 32-bit datapath counts as misaligned
      run_instr(1, 1, 0, 2'd3, 0, 32'h108, 32'h33, 5'd7, 0, 0, 32'h0, 0);
      // ADD then SB held in DONE by downstream stall
      run_instr(1, 0, 0, 2'd0, 0, 32'h55AA, 32'h9, 5'd8, 0, 0, 32'h0, 0);
      run_instr(1, 0, 1, 2'd0, 0, 32'h0A2, 32'h000000C3, 5'd9, 1, 0, 32'h0, 3);
      // SH on the upper half
      run_instr(1, 0, 1, 2'd1, 0, 32'h102, 32'h00001234, 5'd10, 0, 0, 32'h0, 1);

      // Reset while a load waits for data, then a stray rvalid
      valid_i = 1'b1; mem_re_i = 1'b1; mem_we_i = 1'b0; mem_size_i = WORD;
      mem_unsigned_i = 1'b0; alu_result_i = 32'h200; data_i = '0; sel_rd_i = 5'd11;
      #1;
      chk("rw_issue_stall", stall_o, 1);
      @(negedge clk);
      #1;
      chk("rw_req", dmem_req_o, 1);
      dmem_gnt_i = 1'b1;
      @(negedge clk);
      dmem_gnt_i = 1'b0;
      #1;
      chk("rw_wait_stall", stall_o, 1);
      rst_n = 1'b0;
      valid_i = 1'b0; mem_re_i = 1'b0; alu_result_i = '0; sel_rd_i = '0;
      #1;
      chk("rw_rst_stall", stall_o, 0);
      chk("rw_rst_req", dmem_req_o, 0);
      chk("rw_rst_we", mem_we_o, 0);
      chk("rw_rst_rd", sel_rd_o, 0);
      chk("rw_rst_alu", alu_result_o, 0);
      chk("rw_rst_data", data_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i  = 32'hCAFE0001;
      chk("stray_stall", stall_o, 0);
      chk("stray_req", dmem_req_o, 0);
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
      #1;
      chk("stray_stall_after", stall_o, 0);
      chk("stray_data", data_o, 0);
      prev_alu  = '0;
      prev_data = '0;
      run_instr(1, 1, 0, 2'd1, 1, 32'h206, 32'h0, 5'd12, 0, 1, 32'h8001F00D, 0);

      // Random instructions
      for (int n = 0; n < 80; n++) begin
         kind  = $urandom_range(0, 2);
         v     = ($urandom_range(0, 7) != 0);
         re    = (kind == 1);
         we    = (kind == 2);
         sz    = 2'($urandom_range(0, 3));
         uns   = 1'($urandom_range(0, 1));
         addr  = $urandom;
         if ($urandom_range(0, 1) == 1) addr[2:0] = 3'b000;
         data  = $urandom;
         rdata = $urandom;
         rd    = 5'($urandom_range(0, 31));
         run_instr(v, re, we, sz, uns, addr, data, rd, $urandom_range(0, 3),
                   $urandom_range(0, 3), rdata, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
